top_fdct_sdiv_29s_13s_16_seq: RTL

- Iterative signed divider; the inverse operation of the fdct 16s×13s→29 product path.
- Takes a 29-bit signed product-domain value and a 13-bit signed coefficient; returns a 16-bit signed saturated quotient and a 13-bit signed remainder.
- Used by the quantize/descale stage after the fdct multiplier array.
- Valid/ready on both sides, one division in flight.

---
 rtl/top_fdct_div_pkg.sv | 27 ++
 rtl/top_fdct_sdiv_29s_13s_16_seq_if.sv | 32 +++
 rtl/top_fdct_sdiv_step.sv | 29 ++
 rtl/top_fdct_sdiv_29s_13s_16_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/top_fdct_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_fdct_div_pkg
// Description : Shared widths, saturation limits and FSM state encoding for
//               the fdct signed iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
package top_fdct_div_pkg;

    localparam int DIVIDEND_W = 29;
    localparam int DIVISOR_W  = 13;
    localparam int QUOT_W     = 16;
    localparam int REM_W      = DIVISOR_W + 1;   // partial remainder width
    localparam int CNT_W      = 5;               // holds DIVIDEND_W-1

    localparam logic signed [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic signed [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/top_fdct_sdiv_29s_13s_16_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : top_fdct_sdiv_29s_13s_16_seq_if
// Description : Operand / result valid-ready bundle of the signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface top_fdct_sdiv_29s_13s_16_seq_if;
    import top_fdct_div_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic signed [DIVIDEND_W-1:0] dividend;
    logic signed [DIVISOR_W-1:0]  divisor;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [QUOT_W-1:0]     quotient;
    logic signed [DIVISOR_W-1:0]  remainder;
    logic                         ovf;
    logic                         dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dz
    );

endinterface
`default_nettype wire

// File: rtl/top_fdct_sdiv_step.sv
`default_nettype none
// ============================================================================
// Module      : top_fdct_sdiv_step
// Description : One restoring-division step on unsigned magnitudes: shift in
//               the next dividend bit, trial-subtract the divisor, keep the
//               difference when it does not go negative.
// Revision    : 1.0 - initial release
// ============================================================================
module top_fdct_sdiv_step
    import top_fdct_div_pkg::*;
(
    input  wire logic [REM_W-1:0]     i_prem,
    input  wire logic                 i_bit,
    input  wire logic [DIVISOR_W-1:0] i_dvsr,
    output logic      [REM_W-1:0]     o_prem,
    output logic                      o_qbit
);

    logic [REM_W:0]   w_shift;
    logic [REM_W-1:0] w_diff;

    assign w_shift = {i_prem, i_bit};
    assign o_qbit  = (w_shift >= {2'b00, i_dvsr});
    // Only consumed when the subtraction succeeds, so the result is < divisor
    assign w_diff  = w_shift[REM_W-1:0] - {1'b0, i_dvsr};
    assign o_prem  = o_qbit ? w_diff : w_shift[REM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/top_fdct_sdiv_29s_13s_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : top_fdct_sdiv_29s_13s_16_seq
// Description : Iterative signed divider 29s / 13s -> 16s saturated quotient
//               and 13s remainder, one quotient bit per cycle, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module top_fdct_sdiv_29s_13s_16_seq
    import top_fdct_div_pkg::*;
(
    input  wire logic ap_clk,
    input  wire logic ap_rst,
    top_fdct_sdiv_29s_13s_16_seq_if.slave bus
);

    state_t                  r_state, w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [DIVIDEND_W-1:0]   r_dvnd;     // dividend magnitude, shifted out MSB first
    logic [DIVISOR_W-1:0]    r_dvsr;     // divisor magnitude
    logic [DIVIDEND_W-1:0]   r_qmag;
    logic [REM_W-1:0]        r_prem;
    logic                    r_sign_q, r_sign_r, r_zdiv;
    logic signed [QUOT_W-1:0]    r_quot;
    logic signed [DIVISOR_W-1:0] r_rem;
    logic                    r_ovf, r_dz;

    logic                    w_accept;
    logic [DIVIDEND_W-1:0]   w_dvnd_mag;
    logic [DIVISOR_W-1:0]    w_dvsr_mag;
    logic [REM_W-1:0]        w_step_prem;
    logic                    w_step_qbit;
    logic signed [DIVIDEND_W:0]  w_qs;
    logic signed [DIVISOR_W-1:0] w_rs;

    assign w_accept = bus.in_valid && (r_state == IDLE);

    // Two's-complement negation inside the operand width is an exact unsigned
    // magnitude even for the most negative value (2^28, 4096).
    assign w_dvnd_mag = bus.dividend[DIVIDEND_W-1] ? (DIVIDEND_W'(0) - bus.dividend)
                                                   : bus.dividend;
    assign w_dvsr_mag = bus.divisor[DIVISOR_W-1]   ? (DIVISOR_W'(0) - bus.divisor)
                                                   : bus.divisor;

    top_fdct_sdiv_step u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvnd[DIVIDEND_W-1]),
        .i_dvsr (r_dvsr),
        .o_prem (w_step_prem),
        .o_qbit (w_step_qbit)
    );

    // Signed quotient needs one extra bit so +2^28 is representable before saturation
    assign w_qs = r_sign_q ? -$signed({1'b0, r_qmag}) : $signed({1'b0, r_qmag});
    assign w_rs = r_sign_r ? $signed(DIVISOR_W'(0) - r_prem[DIVISOR_W-1:0])
                           : $signed(r_prem[DIVISOR_W-1:0]);

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = (bus.divisor == '0) ? FIX : CALC;
            CALC: if (r_cnt == '0) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_cnt    <= '0;
            r_dvnd   <= '0;
            r_dvsr   <= '0;
            r_qmag   <= '0;
            r_prem   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zdiv   <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (w_accept) begin
                    r_dvnd   <= w_dvnd_mag;
                    r_dvsr   <= w_dvsr_mag;
                    r_sign_q <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
                    r_sign_r <= bus.dividend[DIVIDEND_W-1];
                    r_zdiv   <= (bus.divisor == '0);
                    r_qmag   <= '0;
                    r_prem   <= '0;
                    r_cnt    <= CNT_W'(DIVIDEND_W - 1);
                end
                CALC: begin
                    r_prem <= w_step_prem;
                    r_dvnd <= {r_dvnd[DIVIDEND_W-2:0], 1'b0};
                    r_qmag <= {r_qmag[DIVIDEND_W-2:0], w_step_qbit};
                    r_cnt  <= r_cnt - 1'b1;
                end
                FIX: begin
                    if (r_zdiv) begin
                        r_quot <= r_sign_r ? QUOT_MIN : QUOT_MAX;
                        r_rem  <= '0;
                        r_ovf  <= 1'b0;
                        r_dz   <= 1'b1;
                    end else begin
                        r_rem  <= w_rs;
                        r_dz   <= 1'b0;
                        if (w_qs > $signed((DIVIDEND_W+1)'(QUOT_MAX))) begin
                            r_quot <= QUOT_MAX;
                            r_ovf  <= 1'b1;
                        end else if (w_qs < (DIVIDEND_W+1)'(QUOT_MIN)) begin
                            r_quot <= QUOT_MIN;
                            r_ovf  <= 1'b1;
                        end else begin
                            r_quot <= w_qs[QUOT_W-1:0];
                            r_ovf  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.ovf       = r_ovf;
    assign bus.dz        = r_dz;

endmodule
`default_nettype wire
